// File: rtl/seg_scan_4digit.sv
// seg_scan_4digit
//   Display stage for a 4-digit BCD stopwatch. The four digits are snapshotted
//   once per frame and shown one at a time on a common-anode seven-segment
//   display. Each digit gets SCAN_DIV clock cycles.
//
// Ports
//   clk        : system clock; all logic runs on its rising edge
//   BTNU       : synchronous active-high reset
//   en0..en3   : BCD digits, en0 least significant
//   an         : digit anodes, active-low one-hot (an[i] selects digit i)
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_tick : one-cycle pulse in the first cycle digit 0 of a new frame is shown
module seg_scan_4digit #(
  parameter int SCAN_DIV = 100000,
  parameter int DP_POS   = 2,
  parameter int BLANK_LZ = 1
) (
  input  logic       clk,
  input  logic       BTNU,
  input  logic [3:0] en0,
  input  logic [3:0] en1,
  input  logic [3:0] en2,
  input  logic [3:0] en3,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  // The count must hold SCAN_DIV-1, so it needs ceil(log2(SCAN_DIV)) bits.
  localparam int              CW     = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(SCAN_DIV - 1);
  // Values 4..7 never match a 2-bit slot index, so they mean no decimal point.
  localparam logic [2:0]      DP_IDX = 3'(DP_POS);

  logic [CW-1:0] r_count;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;

  logic          w_tick;
  logic [1:0]    w_idx_nxt;
  logic          w_snap;
  logic [15:0]   w_shadow_nxt;
  logic [3:0]    w_zero;
  logic [3:0]    w_blank;
  logic [3:0]    w_digit;
  logic          w_blank_sel;
  logic [3:0]    w_an_nxt;
  logic [6:0]    w_seg_nxt;
  logic          w_dp_nxt;

  // BCD to active-low segment pattern; anything outside 0..9 shows a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign w_tick    = (r_count == C_LAST);
  assign w_idx_nxt = r_idx + 2'd1;
  assign w_snap    = w_tick && (w_idx_nxt == 2'd0);

  // The output registers are loaded from the shadow as it will be after this
  // edge, so digit 0 shows the freshly captured value in its own slot.
  assign w_shadow_nxt = w_snap ? {en3, en2, en1, en0} : r_shadow;

  // Per-digit zero flags. A non-BCD code is nonzero, so it is never blanked.
  always_comb begin
    w_zero[0] = (w_shadow_nxt[3:0]   == 4'd0);
    w_zero[1] = (w_shadow_nxt[7:4]   == 4'd0);
    w_zero[2] = (w_shadow_nxt[11:8]  == 4'd0);
    w_zero[3] = (w_shadow_nxt[15:12] == 4'd0);
  end

  // Leading-zero blanking. A digit is blanked only if it sits above the
  // decimal point and it and every digit above it are zero. Digit 0 can never
  // be above the decimal point.
  always_comb begin
    w_blank = 4'b0000;
    if (BLANK_LZ == 1) begin
      w_blank[3] = (DP_POS < 3) && w_zero[3];
      w_blank[2] = (DP_POS < 2) && w_zero[3] && w_zero[2];
      w_blank[1] = (DP_POS < 1) && w_zero[3] && w_zero[2] && w_zero[1];
      w_blank[0] = 1'b0;
    end else begin
      w_blank = 4'b0000;
    end
  end

  // Next display values for the slot that becomes active on this tick.
  always_comb begin
    w_digit     = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];
    w_blank_sel = w_blank[w_idx_nxt];
    if (w_blank_sel) begin
      w_an_nxt  = 4'b1111;
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
    end else begin
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt = decode(w_digit);
      w_dp_nxt  = ({1'b0, w_idx_nxt} == DP_IDX) ? 1'b0 : 1'b1;
    end
  end

  // Slot divider, slot index, frame snapshot and registered display outputs.
  always_ff @(posedge clk) begin
    if (BTNU) begin
      r_count    <= '0;
      r_idx      <= 2'd3;
      r_shadow   <= 16'h0000;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (w_tick) begin
        r_count    <= '0;
        r_idx      <= w_idx_nxt;
        r_shadow   <= w_shadow_nxt;
        an         <= w_an_nxt;
        seg        <= w_seg_nxt;
        dp         <= w_dp_nxt;
        frame_tick <= w_snap;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_4digit.sv
// Directed bench for seg_scan_4digit. Instance A uses SCAN_DIV=4 with
// leading-zero blanking, B is the same without blanking, and C uses a long
// slot to exercise a wide divider and the frame period.
module tb_seg_scan_4digit;

  localparam int DIV_C = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_c = 1'b1;
  logic [3:0] en0, en1, en2, en3;

  logic [3:0] an_a, an_b, an_c;
  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic       ft_a, ft_b, ft_c;

  int errors = 0;
  int checks = 0;
  int e_cnt  = 0;

  always #5 clk = ~clk;

  seg_scan_4digit #(.SCAN_DIV(4), .DP_POS(2), .BLANK_LZ(1)) dut_a (
    .clk(clk), .BTNU(rst), .en0(en0), .en1(en1), .en2(en2), .en3(en3),
    .an(an_a), .seg(seg_a), .dp(dp_a), .frame_tick(ft_a));

  seg_scan_4digit #(.SCAN_DIV(4), .DP_POS(2), .BLANK_LZ(0)) dut_b (
    .clk(clk), .BTNU(rst), .en0(en0), .en1(en1), .en2(en2), .en3(en3),
    .an(an_b), .seg(seg_b), .dp(dp_b), .frame_tick(ft_b));

  seg_scan_4digit #(.SCAN_DIV(DIV_C), .DP_POS(2), .BLANK_LZ(1)) dut_c (
    .clk(clk), .BTNU(rst_c), .en0(en0), .en1(en1), .en2(en2), .en3(en3),
    .an(an_c), .seg(seg_c), .dp(dp_c), .frame_tick(ft_c));

  // Advance to edge number 'target' counted from the last reset release,
  // leaving time 1 unit after that edge for sampling and driving.
  task automatic go_to(input int target);
    while (e_cnt < target) begin
      @(posedge clk);
      #1;
      e_cnt++;
    end
  endtask

  // Compare the full output state {an,seg,dp,frame_tick} of one instance.
  task automatic chk(input string tag, input logic [12:0] obs, input logic [3:0] an_e,
                     input logic [6:0] seg_e, input logic dp_e, input logic ft_e);
    logic [12:0] exp_v;
    exp_v = {an_e, seg_e, dp_e, ft_e};
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed an=%b seg=%h dp=%b ft=%b expected an=%b seg=%h dp=%b ft=%b",
             tag, obs[12:9], obs[8:2], obs[1], obs[0], an_e, seg_e, dp_e, ft_e);
    end
  endtask

  task automatic cnt_chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [12:0] sa();
    return {an_a, seg_a, dp_a, ft_a};
  endfunction

  function automatic logic [12:0] sb();
    return {an_b, seg_b, dp_b, ft_b};
  endfunction

  initial begin
    int n;
    {en3, en2, en1, en0} = {4'd3, 4'd2, 4'd1, 4'd0};
    rst = 1'b1;
    go_to(3);
    chk("reset_a", sa(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    chk("reset_b", sb(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    e_cnt = 0;

    // First frame of 3,2,1,0.
    go_to(1); chk("dark_e1", sa(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    go_to(2); chk("dark_e2", sa(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    go_to(3); chk("dark_e3", sa(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    go_to(4); chk("dig0_first", sa(), 4'b1110, 7'h40, 1'b1, 1'b1);
    go_to(5); chk("ft_one_cycle", sa(), 4'b1110, 7'h40, 1'b1, 1'b0);
    go_to(8); chk("dig1_first", sa(), 4'b1101, 7'h79, 1'b1, 1'b0);
    go_to(12); chk("dig2_dp", sa(), 4'b1011, 7'h24, 1'b0, 1'b0);
    go_to(16); chk("dig3_three", sa(), 4'b0111, 7'h30, 1'b1, 1'b0);
    go_to(20); chk("frame2_dig0", sa(), 4'b1110, 7'h40, 1'b1, 1'b1);

    // Leading zeros: 0,0,0,5 is captured at the snapshot of edge 36.
    {en3, en2, en1, en0} = {4'd0, 4'd0, 4'd0, 4'd5};
    go_to(36); chk("lz_dig0", sa(), 4'b1110, 7'h12, 1'b1, 1'b1);
    chk("lz_dig0_b", sb(), 4'b1110, 7'h12, 1'b1, 1'b1);
    go_to(37); chk("lz_ft_low", sa(), 4'b1110, 7'h12, 1'b1, 1'b0);
    en0 = 4'd6;  // must stay invisible until the next snapshot
    go_to(39); chk("snap_hold", sa(), 4'b1110, 7'h12, 1'b1, 1'b0);
    go_to(40); chk("lz_dig1_shown", sa(), 4'b1101, 7'h40, 1'b1, 1'b0);
    go_to(44); chk("lz_dig2_dp", sa(), 4'b1011, 7'h40, 1'b0, 1'b0);
    go_to(48); chk("lz_dig3_blank", sa(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    chk("nolz_dig3", sb(), 4'b0111, 7'h40, 1'b1, 1'b0);
    go_to(52); chk("snap_new", sa(), 4'b1110, 7'h02, 1'b1, 1'b1);

    // Non-BCD digits: C,0,C,6.
    {en3, en2, en1, en0} = {4'hC, 4'd0, 4'hC, 4'd6};
    go_to(68); chk("nb_dig0", sa(), 4'b1110, 7'h02, 1'b1, 1'b1);
    go_to(72); chk("nb_dig1_dash", sa(), 4'b1101, 7'h3F, 1'b1, 1'b0);
    go_to(76); chk("nb_dig2", sa(), 4'b1011, 7'h40, 1'b0, 1'b0);

    // Reset in the middle of the digit2 slot.
    go_to(77);
    rst = 1'b1;
    go_to(78); chk("midrst_a", sa(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    chk("midrst_b", sb(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    rst = 1'b0;
    e_cnt = 0;
    go_to(3); chk("midrst_dark_e3", sa(), 4'b1111, 7'h7F, 1'b1, 1'b0);
    go_to(4); chk("midrst_dig0", sa(), 4'b1110, 7'h02, 1'b1, 1'b1);
    go_to(8); chk("midrst_dig1", sa(), 4'b1101, 7'h3F, 1'b1, 1'b0);
    go_to(12); chk("midrst_dig2", sa(), 4'b1011, 7'h40, 1'b0, 1'b0);
    go_to(16); chk("nb_dig3_shown", sa(), 4'b0111, 7'h3F, 1'b1, 1'b0);

    // Long-slot instance: first digit 0 after DIV_C edges, then 4*DIV_C apart.
    @(posedge clk); #1;
    rst_c = 1'b1;
    @(posedge clk); #1;
    chk("reset_c", {an_c, seg_c, dp_c, ft_c}, 4'b1111, 7'h7F, 1'b1, 1'b0);
    rst_c = 1'b0;
    n = 0;
    while (ft_c !== 1'b1 && n < 6 * DIV_C) begin
      @(posedge clk); #1;
      n++;
    end
    cnt_chk("c_first_tick", n, DIV_C);
    chk("c_dig0", {an_c, seg_c, dp_c, ft_c}, 4'b1110, 7'h02, 1'b1, 1'b1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ft_c !== 1'b1 && n < 6 * DIV_C);
    cnt_chk("c_frame_period", n, 4 * DIV_C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
